// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with loadable pattern, KMP fallback,
// overlap/non-overlap mode and a saturating match counter.
module seq_detector_param #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011),
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             x_valid,
   input  logic             overlap_en,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             z,
   output logic [CNT_W-1:0] match_count,
   output logic [PAT_W-1:0] pattern
);

   localparam int SW = $clog2(PAT_W + 1);

   typedef logic [SW-1:0] state_t;

   localparam state_t         MATCH = state_t'(PAT_W);
   localparam logic [CNT_W-1:0] CMAX = '1;

   state_t state;
   state_t nstate;
   logic   hit;

   // Longest pattern prefix that is a suffix of (first k pattern bits, x).
   // Bit strings are right-aligned so prefixes and suffixes become shifts.
   function automatic state_t kmp_next(
      input logic [PAT_W-1:0] p,
      input state_t           k,
      input logic             xb
   );
      logic [PAT_W:0] pe;
      logic [PAT_W:0] s;
      logic [PAT_W:0] pre;
      logic [PAT_W:0] msk;
      state_t         best;
      pe   = {1'b0, p};
      s    = ((pe >> (PAT_W - int'(k))) << 1) | {{PAT_W{1'b0}}, xb};
      best = '0;
      for (int j = 1; j <= PAT_W; j++) begin
         pre = pe >> (PAT_W - j);
         msk = {(PAT_W + 1){1'b1}} >> (PAT_W + 1 - j);
         if (j <= int'(k) + 1 && ((s ^ pre) & msk) == '0)
            best = SW'(j);
      end
      return best;
   endfunction

   always_comb begin
      nstate = state;
      hit    = 1'b0;
      if (x_valid) begin
         if (state == MATCH && !overlap_en)
            nstate = (x == pattern[PAT_W-1]) ? state_t'(1) : '0;
         else
            nstate = kmp_next(pattern, state, x);
         hit = (nstate == MATCH);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= '0;
         pattern <= PAT_RST;
      end else if (pat_load) begin
         state   <= '0;
         pattern <= pat_in;
      end else begin
         state   <= nstate;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         match_count <= '0;
      else if (cnt_clr)
         match_count <= '0;
      else if (hit && !pat_load && match_count != CMAX)
         match_count <= match_count + 1'b1;
   end

   assign z = (state == MATCH);

endmodule
